// File: rtl/ndata_serializer_pkg.sv
// Shared types and lane-mask helpers for the wide-to-narrow element serializer.
// Helpers take a mask zero-extended to MAX_LANES so one function serves any lane count.
package ndata_serializer_pkg;

    typedef logic [31:0] data_t;

    localparam int MAX_LANES = 64;
    localparam int MAX_IDX_W = 6;

    function automatic logic [MAX_IDX_W-1:0] lowest_set_idx(input logic [MAX_LANES-1:0] mask);
        lowest_set_idx = '0;
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            if (mask[i]) lowest_set_idx = MAX_IDX_W'(i);
        end
    endfunction

    // True when exactly one lane remains in the mask.
    function automatic logic is_single_bit(input logic [MAX_LANES-1:0] mask);
        return ((mask & (mask - 64'd1)) == '0) && (mask != '0);
    endfunction

endpackage

// File: rtl/ndata_serializer_if.sv
// Valid/ready stream carrying LANES elements with per-lane keep and a packet-closing last.
// The serializer uses LANES=NUM_ELEMENTS on its input and LANES=1 on its output.
interface ndata_serializer_if #(
    parameter int LANES = 1
);
    import ndata_serializer_pkg::*;

    data_t [LANES-1:0] data;
    logic  [LANES-1:0] keep;
    logic              last;
    logic              valid;
    logic              ready;

    modport master (output data, keep, last, valid, input ready);
    modport slave  (input data, keep, last, valid, output ready);

endinterface

// File: rtl/ndata_serializer_lsb_select.sv
// Combinational lowest-set-lane picker: one-hot lowest bit, its index, and a
// flag for "this is the only bit left".
module lsb_select
    import ndata_serializer_pkg::*;
#(
    parameter int NUM_ELEMENTS = 8,
    parameter int IDX_W        = $clog2(NUM_ELEMENTS)
) (
    input  logic [NUM_ELEMENTS-1:0] mask_i,
    output logic [NUM_ELEMENTS-1:0] onehot_o,
    output logic [IDX_W-1:0]        idx_o,
    output logic                    single_o
);

    logic [MAX_LANES-1:0] mask_ext;

    always_comb begin
        mask_ext = MAX_LANES'(mask_i);
        onehot_o = mask_i & (-mask_i);
        idx_o    = IDX_W'(lowest_set_idx(mask_ext));
        single_o = is_single_bit(mask_ext);
    end

endmodule

// File: rtl/ndata_serializer.sv
// Serializes kept lanes of each wide beat onto a single-element stream, lowest lane first,
// preserving packet last; an all-empty last beat becomes a keep=0 terminator element.
module ndata_serializer
    import ndata_serializer_pkg::*;
#(
    parameter int NUM_ELEMENTS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    ndata_serializer_if.slave  in,
    ndata_serializer_if.master out
);

    localparam int IDX_W = $clog2(NUM_ELEMENTS);

    data_t [NUM_ELEMENTS-1:0] data_q;
    logic  [NUM_ELEMENTS-1:0] pend_q, pend_d;
    logic                     busy_q, busy_d;
    logic                     last_q, last_d;
    logic                     term_q, term_d;

    logic [NUM_ELEMENTS-1:0]  sel_onehot;
    logic [IDX_W-1:0]         sel_idx;
    logic                     sel_single;
    logic                     fin;
    logic                     in_rdy;
    logic                     load;

    lsb_select #(
        .NUM_ELEMENTS (NUM_ELEMENTS)
    ) u_lsb_select (
        .mask_i   (pend_q),
        .onehot_o (sel_onehot),
        .idx_o    (sel_idx),
        .single_o (sel_single)
    );

    // A beat may be taken in the same cycle the previous one hands off its final element.
    always_comb begin
        fin          = busy_q && out.ready && (term_q || sel_single);
        in_rdy       = !busy_q || fin;
        load         = in.valid && in_rdy && ((|in.keep) || in.last);
        in.ready     = in_rdy;
        out.valid    = busy_q;
        out.data[0]  = data_q[sel_idx];
        out.keep[0]  = busy_q && !term_q;
        out.last     = busy_q && last_q && (term_q || sel_single);
    end

    always_comb begin
        busy_d = busy_q;
        pend_d = pend_q;
        last_d = last_q;
        term_d = term_q;
        if (load) begin
            busy_d = 1'b1;
            last_d = in.last;
            if (|in.keep) begin
                pend_d = in.keep;
                term_d = 1'b0;
            end else begin
                pend_d = '0;
                term_d = 1'b1;
            end
        end else if (fin) begin
            busy_d = 1'b0;
            pend_d = '0;
            last_d = 1'b0;
            term_d = 1'b0;
        end else if (busy_q && out.ready) begin
            pend_d = pend_q & ~sel_onehot;
        end
    end

    // Lane data carries no reset; it is only observed while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            pend_q <= '0;
            last_q <= 1'b0;
            term_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
            last_q <= last_d;
            term_q <= term_d;
            if (load && (|in.keep)) data_q <= in.data;
        end
    end

endmodule
